// File: rtl/h_reset_sequencer.sv
// Multi-domain reset sequencer: releases NUM_STAGES reset domains in index
// order, gated on each stage's ready and a gap; supervises drops/timeouts.
//
// Ports:
//   Clock        sole clock
//   qResetN      async active-low reset (deassertion pre-synchronised)
//   Restart      one-cycle software restart request
//   StageReady   per-stage ready/lock level, synchronous to Clock
//   qStageReset  active-high registered reset per stage domain
//   AllReady     all stages released and ready
//   Busy         sequence in progress (HOLD/WAIT/DELAY)
//   Fault        timeout fault latched
//   FaultStage   index of the stage that timed out, valid while Fault
module h_reset_sequencer #(
  parameter int NUM_STAGES  = 4,
  parameter int HOLD_CYCLES = 64,
  parameter int STAGE_DELAY = 16,
  parameter int TIMEOUT     = 65535,
  parameter int CNT_W       = 16,
  localparam int IW         = $clog2(NUM_STAGES)
) (
  input  logic                  Clock,
  input  logic                  qResetN,
  input  logic                  Restart,
  input  logic [NUM_STAGES-1:0] StageReady,
  output logic [NUM_STAGES-1:0] qStageReset,
  output logic                  AllReady,
  output logic                  Busy,
  output logic                  Fault,
  output logic [IW-1:0]         FaultStage
);

  typedef enum logic [2:0] {
    HOLD,
    WAIT,
    DELAY,
    RUN,
    FAULT
  } state_e;

  localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_END  = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] TO_END   = CNT_W'(TIMEOUT - 1);
  localparam logic [IW-1:0]    LAST     = IW'(NUM_STAGES - 1);

  state_e                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d, idx_nx;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_STAGES-1:0]   rst_q, rst_d;
  logic [NUM_STAGES-1:0]   mon, drop;
  logic [IW-1:0]           k;
  logic                    enter;

  // Stages whose ready is supervised: everything in RUN, only the
  // already-released ones below idx while sequencing.
  always_comb begin
    mon = '0;
    k   = '0;
    for (int j = 0; j < NUM_STAGES; j++) begin
      if (state_q == RUN)
        mon[j] = 1'b1;
      else if ((state_q == WAIT || state_q == DELAY) && (IW'(j) < idx_q))
        mon[j] = 1'b1;
    end
    drop = mon & ~StageReady;
    for (int j = NUM_STAGES - 1; j >= 0; j--)
      if (drop[j]) k = IW'(j);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    enter   = 1'b0;
    idx_nx  = idx_q + IW'(1);
    if (Restart) begin
      state_d = HOLD;
      idx_d   = '0;
      rst_d   = '1;
      enter   = 1'b1;
    end else if (|drop) begin
      // Lowest dropped stage and everything above it go back to reset.
      state_d = HOLD;
      idx_d   = k;
      enter   = 1'b1;
      for (int j = 0; j < NUM_STAGES; j++)
        if (IW'(j) >= k) rst_d[j] = 1'b1;
    end else begin
      unique case (state_q)
        HOLD: begin
          if (cnt_q == HOLD_END) begin
            rst_d[idx_q] = 1'b0;
            state_d      = WAIT;
            enter        = 1'b1;
          end
        end
        WAIT: begin
          if (StageReady[idx_q]) begin
            state_d = (idx_q == LAST) ? RUN : DELAY;
            enter   = 1'b1;
          end else if (cnt_q == TO_END) begin
            state_d = FAULT;
            rst_d   = '1;
            enter   = 1'b1;
          end
        end
        DELAY: begin
          if (cnt_q == DLY_END) begin
            idx_d         = idx_nx;
            rst_d[idx_nx] = 1'b0;
            state_d       = WAIT;
            enter         = 1'b1;
          end
        end
        RUN, FAULT: ;
        default: begin
          state_d = HOLD;
          rst_d   = '1;
          enter   = 1'b1;
        end
      endcase
    end
    if (enter)
      cnt_d = '0;
    else if (&cnt_q)
      cnt_d = cnt_q;
    else
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge Clock or negedge qResetN) begin
    if (!qResetN) begin
      state_q <= HOLD;
      idx_q   <= '0;
      cnt_q   <= '0;
      rst_q   <= '1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
    end
  end

  assign qStageReset = rst_q;
  assign AllReady    = (state_q == RUN);
  assign Busy        = (state_q == HOLD) || (state_q == WAIT) ||
                       (state_q == DELAY);
  assign Fault       = (state_q == FAULT);
  assign FaultStage  = Fault ? idx_q : '0;

endmodule

// File: doc/h_reset_sequencer.md
# h_reset_sequencer

Multi-domain reset sequencer. It takes one board/system reset, already synchronised to `Clock`, and releases up to `NUM_STAGES` downstream reset domains in fixed index order. Before each next stage is released, it waits for the previous stage's ready/lock indication, then a programmable gap. It sits directly behind the per-clock reset synchroniser and drives the active-high reset inputs of the datapath subsystems: PLL/transceiver first, then MAC, switch core and management. It also supervises loss-of-ready, timeout faults and software restart.

## Interface
- `NUM_STAGES`, default 4: number of sequenced reset domains, 2..16.
- `HOLD_CYCLES`, default 64: cycles all stage resets are held after reset/restart/ready-loss; ≥1.
- `STAGE_DELAY`, default 16: gap cycles between ready of stage i and release of stage i+1; ≥1.
- `TIMEOUT`, default 65535: cycles allowed for `StageReady[i]` after release of stage i; ≥2.
- `CNT_W`, default 16: counter width; must hold max(`HOLD_CYCLES`, `STAGE_DELAY`, `TIMEOUT`).
- `Clock` (in, 1): sole clock.
- `qResetN` (in, 1): asynchronous active-low reset. Assertion is asynchronous; deassertion must come already synchronised to `Clock` from upstream.
- `Restart` (in, 1): synchronous one-cycle software restart request.
- `StageReady` (in, `NUM_STAGES`): per-stage ready/lock, already synchronous to `Clock`; level.
- `qStageReset` (out, `NUM_STAGES`): active-high registered reset per stage domain.
- `AllReady` (out, 1): all stages released and ready.
- `Busy` (out, 1): sequence in progress (states HOLD/WAIT/DELAY).
- `Fault` (out, 1): timeout fault latched.
- `FaultStage` (out, clog2(`NUM_STAGES`)): index of the stage that timed out; valid while `Fault`=1.

## Operation
- The state is one of HOLD, WAIT, DELAY, RUN, FAULT. It has a stage index `idx` and a single counter `cnt`, reset to 0 on every state entry.
- Async reset (`qResetN`=0) gives: state HOLD, `idx`=0, `cnt`=0, `qStageReset`=all 1, `AllReady`=0, `Busy`=1, `Fault`=0, `FaultStage`=0.
- HOLD: every stage j≥`idx` is held at `qStageReset[j]`=1. On the edge where `cnt`=`HOLD_CYCLES`-1, the block clears `qStageReset[idx]` and moves to WAIT.
- WAIT: if `StageReady[idx]`=1, the next state is DELAY. If `idx`=`NUM_STAGES`-1, it goes to RUN instead. Ready sampled on the same edge as the timeout takes priority over the timeout. Otherwise, if `cnt`=`TIMEOUT`-1, the next state is FAULT.
- DELAY: on the edge where `cnt`=`STAGE_DELAY`-1, the block increments `idx`, clears `qStageReset[idx+1]` and returns to WAIT.
- RUN: `AllReady`=1 and `Busy`=0.
  - If any `StageReady[j]`=1→0, let k be the lowest dropped index. The block sets `qStageReset[NUM_STAGES-1:k]`=1 and `AllReady`=0, loads `idx`=k and enters HOLD. Stages below k stay released.
- FAULT: all `qStageReset`=1, `Fault`=1, `FaultStage`=the `idx` of the stage that timed out, `Busy`=0. The block stays in FAULT until `Restart`.
- `Restart`=1 in any state has the highest priority, above timeout and ready. On that edge all `qStageReset`=1, `idx`=0, `Fault`=0, `AllReady`=0, and the state becomes HOLD.
- Ready of stages already released (index < `idx`) is also monitored during WAIT/DELAY. A drop is handled the same way as in RUN, using the lowest dropped index k < `idx`.
- The counter saturates; wrap-around is forbidden.

## Timing
- All outputs are registered; there is no combinational input→output path.
- Edges are numbered from the first rising edge after `qResetN` deasserts, which is edge 1.
- `qStageReset[0]` falls at edge `HOLD_CYCLES`.
- A ready sampled at edge t in WAIT releases the next stage at edge t+`STAGE_DELAY`.
- For the last stage, a ready sampled at edge t gives `AllReady`=1 at edge t.
- Timeout: release at edge r with no ready gives FAULT (`Fault`=1, all resets asserted) at edge r+`TIMEOUT`.
- Ready loss sampled at edge t in RUN gives resets asserted and `AllReady`=0 at edge t. Re-release follows `HOLD_CYCLES` edges later.
- `qResetN` assertion mid-sequence: all outputs go to reset values immediately, without waiting for a clock edge.

## Test plan
- Nominal sequence (`NUM_STAGES`=4, `HOLD_CYCLES`=8, `STAGE_DELAY`=4, `TIMEOUT`=32, `StageReady`=4'hF):
  - `qStageReset[0..3]` falls at edges 8/13/18/23.
  - `AllReady`=1 at edge 24 and `Busy`=0 at edge 24.
- Timeout: same configuration, `StageReady[1]` held at 0. `Fault`=1 and `FaultStage`=1 at edge 45, with `qStageReset`=4'hF.
  - `Restart` at edge 60, with `StageReady[1]` still held at 0: `Fault`=0 at edge 60. After the restart the sequence runs again: stage 0 is re-released, stage 1 is released and times out again.
- Ready loss in RUN: drop `StageReady[2]` at edge 30. At edge 30 `qStageReset`=4'b1100 and `AllReady`=0. Stage 2 is re-released at edge 38, and `AllReady`=1 at edge 44 with stages 2 and 3 ready.
- Simultaneous events: `StageReady[idx]` rises on the exact timeout edge → no fault, sequence proceeds. `Restart` on the same edge as the last-stage ready → HOLD, `AllReady` stays 0.
- Async reset mid-DELAY: pulse `qResetN` low for 3 ns between edges. All outputs return to reset values before the next edge, and the sequence restarts with stage 0 at edge `HOLD_CYCLES` after release.
